// File: rtl/cloud_pkg.sv
// Shared constants and types for the background cloud layer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: sky-level/gap limits, scheduler pool size, LFSR seed, the
// spawn ranges derived from the limits, and the scheduler state type.
package cloud_pkg;

  // Sky level counts down the screen, so MIN is numerically the larger value.
  localparam int MIN_SKY_LEVEL = 101;
  localparam int MAX_SKY_LEVEL = 60;
  localparam int MIN_CLOUD_GAP = 100;
  localparam int MAX_CLOUD_GAP = 400;

  localparam int          NUM_CLOUDS  = 6;
  localparam int          GAME_WIDTH  = 640;
  localparam int          LEVEL_RANGE = MIN_SKY_LEVEL - MAX_SKY_LEVEL + 1;
  localparam int          GAP_RANGE   = MAX_CLOUD_GAP - MIN_CLOUD_GAP + 1;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  typedef enum logic [2:0] {
    SCHED_IDLE,
    SCHED_RUNNING,
    SCHED_EVAL,
    SCHED_PENDING,
    SCHED_CRASHED
  } sched_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, free running.
// Latency: new value every cycle.
// Backpressure: none; it never stalls.
// Ports: clk, rst_n (async active-low, loads SEED), lfsr_o (current state).
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Right-shift form: the bit leaving at the bottom is folded back into
  // taps 16,14,13,11 (mask 0xB400).
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/cloud_scheduler.sv
// Cloud spawn controller: per update tick decides whether the lowest free slot starts.
// Latency: start visible 2 cycles after the deciding update, held until the next update.
// Backpressure: none; a full pool or a too-close previous cloud simply skips the tick.
// Ports: update/run/crash game events, remove/gap/x_pos from the cloud array;
// start strobe, level_rand/gap_rand spawn offsets and active_count outputs.
module cloud_scheduler #(
  parameter int          NUM_CLOUDS  = cloud_pkg::NUM_CLOUDS,
  parameter int          GAME_WIDTH  = cloud_pkg::GAME_WIDTH,
  parameter int          LEVEL_RANGE = cloud_pkg::LEVEL_RANGE,
  parameter int          GAP_RANGE   = cloud_pkg::GAP_RANGE,
  parameter logic [15:0] LFSR_SEED   = cloud_pkg::LFSR_SEED
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 update,
  input  logic                                 run,
  input  logic                                 crash,
  input  logic [NUM_CLOUDS-1:0]                remove,
  input  logic [NUM_CLOUDS-1:0][10:0]          gap,
  input  logic signed [NUM_CLOUDS-1:0][10:0]   x_pos,
  output logic [NUM_CLOUDS-1:0]                start,
  output logic [9:0]                           level_rand,
  output logic [10:0]                          gap_rand,
  output logic [$clog2(NUM_CLOUDS+1)-1:0]      active_count
);

  import cloud_pkg::*;

  localparam int                 IW      = $clog2(NUM_CLOUDS);
  localparam int                 CW      = $clog2(NUM_CLOUDS + 1);
  localparam logic signed [11:0] WIDTH_S = 12'(GAME_WIDTH);

  sched_state_t          state_q, state_d;
  logic [NUM_CLOUDS-1:0] start_q, start_d;
  logic [NUM_CLOUDS-1:0] busy_q, busy_d;
  logic [NUM_CLOUDS-1:0] remove_q;
  logic [9:0]            level_q, level_d;
  logic [10:0]           gap_q, gap_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         slot_q, slot_d;
  logic [CW-1:0]         count_q, count_d;
  logic [15:0]           lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .lfsr_o (lfsr)
  );

  // Lowest free slot: scan high to low so the lowest index overwrites.
  logic          free_vld;
  logic [IW-1:0] free_idx;
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = NUM_CLOUDS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_vld = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // Spawn once the previous cloud has moved at least its own gap into view.
  // Everything is widened to 12-bit signed so 640 - (-46) = 686 fits.
  logic [10:0]        gap_last, x_last;
  logic signed [11:0] room;
  logic               spawn_ok;
  always_comb begin
    gap_last = gap[last_q];
    x_last   = x_pos[last_q];
    room     = WIDTH_S - $signed({x_last[10], x_last});
    spawn_ok = (count_q == '0) || ($signed({1'b0, gap_last}) < room);
  end

  // Scale the LFSR into [0, RANGE) by taking the top half of the product.
  logic [31:0] lvl_prod, gap_prod;
  logic        unused_prod;
  assign lvl_prod    = {16'd0, lfsr} * 32'(LEVEL_RANGE);
  assign gap_prod    = {16'd0, lfsr} * 32'(GAP_RANGE);
  assign unused_prod = ^{lvl_prod[31:26], lvl_prod[15:0], gap_prod[31:27], gap_prod[15:0]};

  logic spawn, consume;
  assign spawn   = (state_q == SCHED_EVAL) && !crash && free_vld && spawn_ok;
  assign consume = (state_q == SCHED_PENDING) && update && !crash;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SCHED_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCHED_IDLE:    if (run)    state_d = SCHED_RUNNING;
      SCHED_RUNNING: if (update) state_d = SCHED_EVAL;
      SCHED_EVAL:    state_d = (free_vld && spawn_ok) ? SCHED_PENDING : SCHED_RUNNING;
      SCHED_PENDING: if (update) state_d = SCHED_RUNNING;
      SCHED_CRASHED: state_d = SCHED_CRASHED;
      default:       state_d = SCHED_IDLE;
    endcase
    if (crash) state_d = SCHED_CRASHED;
  end

  // Output / occupancy next values
  always_comb begin
    start_d = start_q;
    level_d = level_q;
    gap_d   = gap_q;
    slot_d  = slot_q;
    last_d  = last_q;
    // remove stays high until re-init, so only its rising edge frees a slot.
    busy_d  = busy_q & ~(remove & ~remove_q);
    if (spawn) begin
      start_d           = '0;
      start_d[free_idx] = 1'b1;
      level_d           = lvl_prod[25:16];
      gap_d             = gap_prod[26:16];
      slot_d            = free_idx;
    end
    // Set after clear: a same-cycle set wins over a remove edge.
    if (consume) begin
      busy_d = busy_d | start_q;
      last_d = slot_q;
    end
    if (consume || crash) start_d = '0;
    count_d = '0;
    for (int i = 0; i < NUM_CLOUDS; i++) count_d = count_d + CW'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= '0;
      level_q  <= '0;
      gap_q    <= '0;
      busy_q   <= '0;
      remove_q <= '0;
      last_q   <= '0;
      slot_q   <= '0;
      count_q  <= '0;
    end else begin
      start_q  <= start_d;
      level_q  <= level_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      remove_q <= remove;
      last_q   <= last_d;
      slot_q   <= slot_d;
      count_q  <= count_d;
    end
  end

  assign start        = start_q;
  assign level_rand   = level_q;
  assign gap_rand     = gap_q;
  assign active_count = count_q;

endmodule

// File: tb/tb_cloud_scheduler.sv
// Directed bench for cloud_scheduler: spawn timing, gap rule, pool full,
// remove edge, crash and asynchronous reset.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_cloud_scheduler;

  localparam int N = 6;

  logic                        clk    = 1'b0;
  logic                        rst_n  = 1'b0;
  logic                        update = 1'b0;
  logic                        run    = 1'b0;
  logic                        crash  = 1'b0;
  logic [N-1:0]                remove = '0;
  logic [N-1:0][10:0]          gap;
  logic signed [N-1:0][10:0]   x_pos;
  logic [N-1:0]                start;
  logic [9:0]                  level_rand;
  logic [10:0]                 gap_rand;
  logic [2:0]                  active_count;

  int total = 0;
  int bad   = 0;

  cloud_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .update       (update),
    .run          (run),
    .crash        (crash),
    .remove       (remove),
    .gap          (gap),
    .x_pos        (x_pos),
    .start        (start),
    .level_rand   (level_rand),
    .gap_rand     (gap_rand),
    .active_count (active_count)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shift Galois form.
  logic [15:0] mdl, mdl_prev;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl      <= 16'hACE1;
      mdl_prev <= 16'hACE1;
    end else begin
      mdl_prev <= mdl;
      mdl      <= lfsr_step(mdl);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_update;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  // Update tick, then look at start one cycle later (EVAL has just latched).
  // mdl_prev is then the LFSR value the DUT used for its decision.
  task automatic spawn_check(input string tag, input logic [N-1:0] exp_start);
    logic [31:0] lvl_e, gap_e;
    pulse_update();
    tick(1);
    chk(tag, 32'(start), 32'(exp_start));
    if (exp_start != '0) begin
      lvl_e = (32'(mdl_prev) * 32'd42) >> 16;
      gap_e = (32'(mdl_prev) * 32'd301) >> 16;
      chk({tag, "_lvl"}, 32'(level_rand), lvl_e);
      chk({tag, "_gap"}, 32'(gap_rand), gap_e);
    end
  endtask

  logic [N-1:0] seen;

  initial begin
    gap   = '0;
    x_pos = '0;
    tick(3);
    chk("rst_start", 32'(start), 0);
    chk("rst_level", 32'(level_rand), 0);
    chk("rst_gap", 32'(gap_rand), 0);
    chk("rst_count", 32'(active_count), 0);

    // First spawn into an empty pool.
    rst_n = 1'b1;
    tick(1);
    run = 1'b1;
    tick(2);
    spawn_check("spawn0", 6'b000001);
    tick(3);
    chk("hold0", 32'(start), 1);
    pulse_update();
    chk("consume0", 32'(start), 0);
    chk("count1", 32'(active_count), 1);

    // Gap rule against slot 0: strict less-than.
    gap[0]   = 11'd150;
    x_pos[0] = 11'sd500;
    spawn_check("diff140", 6'b000000);
    x_pos[0] = 11'sd490;
    spawn_check("diff150", 6'b000000);
    x_pos[0] = 11'sd480;
    spawn_check("diff160", 6'b000010);
    pulse_update();
    chk("count2", 32'(active_count), 2);

    // Fill the pool.
    for (int i = 2; i < N; i++) begin
      spawn_check("fill", N'(1) << i);
      pulse_update();
    end
    chk("count6", 32'(active_count), 6);

    // Pool full: no start across 10 updates.
    for (int k = 0; k < 10; k++) spawn_check("full", 6'b000000);

    // Remove edge on slot 2, held high.
    remove[2] = 1'b1;
    tick(1);
    chk("rm_dec", 32'(active_count), 5);
    tick(4);
    chk("rm_hold", 32'(active_count), 5);
    spawn_check("reuse2", 6'b000100);
    pulse_update();
    chk("reuse_count", 32'(active_count), 6);
    remove[2] = 1'b0;
    tick(1);

    // Crash while a start is pending.
    remove[3] = 1'b1;
    tick(1);
    chk("rm3_dec", 32'(active_count), 5);
    spawn_check("pre_crash", 6'b001000);
    crash = 1'b1;
    tick(1);
    crash = 1'b0;
    chk("crash_clr", 32'(start), 0);
    seen = '0;
    for (int k = 0; k < 20; k++) begin
      pulse_update();
      tick(1);
      seen = seen | start;
    end
    chk("crash_quiet", 32'(seen), 0);
    chk("crash_count", 32'(active_count), 5);

    // Reset clears everything, then a spawn is left pending.
    rst_n = 1'b0;
    remove = '0;
    gap    = '0;
    x_pos  = '0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    spawn_check("rst_spawn", 6'b000001);
    // Drop reset between clock edges; start must clear without an edge.
    #2 rst_n = 1'b0;
    #1 chk("async_clr", 32'(start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Three LFSR steps from 0xACE1 give 0x389C: level 9, gap 66.
    tick(2);
    spawn_check("seed_spawn", 6'b000001);
    chk("seed_level", 32'(level_rand), 9);
    chk("seed_gap", 32'(gap_rand), 66);
    pulse_update();

    // Signed boundary: x_pos = -46 gives room 686.
    gap[0]   = 11'd686;
    x_pos[0] = -11'sd46;
    spawn_check("room686_eq", 6'b000000);
    gap[0]   = 11'd685;
    spawn_check("room686_lt", 6'b000010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
